div_sequencer: RTL and testbench

Multi-cycle 32-bit integer divide sequencer for the MIPS execute stage; implements DIV and DIVU with a one-bit-per-cycle restoring algorithm. The EX stage launches it with operands, holds `start_i` while stalled, and consumes the 64-bit {remainder, quotient} result. The result is written to HI/LO via the existing EX HILO write path (remainder to HI, quotient to LO). The block also owns the abort path used when the instruction in EX is flushed.

---
 rtl/div_sequencer_pkg.sv | 25 ++
 rtl/div_step.sv | 23 ++
 rtl/div_sequencer.sv | 108 ++++++++++
 tb/tb_div_sequencer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/div_sequencer_pkg.sv
// Shared encodings for the multi-cycle divide sequencer: FSM states,
// handshake levels, the divide aluop codes and an operand magnitude helper.
package div_sequencer_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

  // Two's-complement magnitude when the operand is treated as signed.
  function automatic logic [31:0] op_mag(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: 33-bit trial subtract of the divisor
// from the partial remainder and select of the next shifted dividend.
module div_step #(
  parameter int unsigned DATA_W = 32
) (
  input  logic [2*DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0]   divisor,
  output logic [2*DATA_W:0]   next_dividend
);

  logic [DATA_W:0] diff;

  // Quotient bits enter at bit 0; the remainder accumulates in the top word.
  always_comb begin
    diff = {1'b0, dividend[2*DATA_W-1:DATA_W]} - {1'b0, divisor};
    if (diff[DATA_W]) begin
      next_dividend = {dividend, 1'b0};
    end else begin
      next_dividend = {diff[DATA_W-1:0], dividend[DATA_W-1:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_sequencer.sv
// DIV/DIVU sequencer for the EX stage: one quotient bit per cycle, sign fix
// on completion, result held until EX drops start_i; annul aborts in flight.
module div_sequencer
  import div_sequencer_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o,
  output logic                  busy_o
);

  div_state_e          state;
  logic [5:0]          cnt;
  logic [2*DATA_W:0]   dividend;
  logic [DATA_W-1:0]   divisor;
  logic                sgn_mode;
  logic                sgn_a;
  logic                sgn_b;

  logic [2*DATA_W:0]   next_dividend;
  logic [DATA_W-1:0]   q_fix;
  logic [DATA_W-1:0]   r_fix;

  div_step #(.DATA_W(DATA_W)) u_step (
    .dividend      (dividend[2*DATA_W-1:0]),
    .divisor       (divisor),
    .next_dividend (next_dividend)
  );

  always_comb begin
    q_fix = dividend[DATA_W-1:0];
    r_fix = dividend[2*DATA_W:DATA_W+1];
    if (sgn_mode && (sgn_a ^ sgn_b)) q_fix = ~q_fix + 1'b1;
    if (sgn_mode && sgn_a)           r_fix = ~r_fix + 1'b1;
  end

  assign busy_o = (state != DivFree);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= DivFree;
      cnt      <= '0;
      dividend <= '0;
      divisor  <= '0;
      sgn_mode <= 1'b0;
      sgn_a    <= 1'b0;
      sgn_b    <= 1'b0;
      result_o <= '0;
      ready_o  <= DivResultNotReady;
    end else begin
      case (state)
        DivFree: begin
          result_o <= '0;
          ready_o  <= DivResultNotReady;
          if (start_i == DivStart && !annul_i) begin
            sgn_mode <= signed_div_i;
            sgn_a    <= opdata1_i[DATA_W-1];
            sgn_b    <= opdata2_i[DATA_W-1];
            if (opdata2_i == '0) begin
              state <= DivByZero;
            end else begin
              state    <= DivOn;
              cnt      <= '0;
              divisor  <= op_mag(opdata2_i, signed_div_i);
              dividend <= {{DATA_W{1'b0}}, op_mag(opdata1_i, signed_div_i), 1'b0};
            end
          end
        end
        DivByZero: begin
          state    <= DivEnd;
          result_o <= '0;
          ready_o  <= DivResultReady;
        end
        DivOn: begin
          if (annul_i) begin
            state    <= DivFree;
            result_o <= '0;
            ready_o  <= DivResultNotReady;
          end else if (cnt != 6'd32) begin
            dividend <= next_dividend;
            cnt      <= cnt + 6'd1;
          end else begin
            state    <= DivEnd;
            result_o <= {r_fix, q_fix};
            ready_o  <= DivResultReady;
          end
        end
        DivEnd: begin
          if (start_i == DivStop || annul_i) begin
            state    <= DivFree;
            result_o <= '0;
            ready_o  <= DivResultNotReady;
          end
        end
        default: state <= DivFree;
      endcase
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: arithmetic reference model checked
// every cycle, plus directed vectors with hand-computed results and latencies.
module tb_div_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        busy_o;

  int n_cmp = 0;
  int n_bad = 0;
  bit checking = 1'b0;

  div_sequencer #(.DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference result from plain integer arithmetic (64-bit to avoid overflow).
  function automatic logic [63:0] ref_div(input bit sd, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [31:0] uq, ur;
    if (b == 32'd0) return 64'd0;
    if (sd) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return {r[31:0], q[31:0]};
    end
    uq = a / b;
    ur = a % b;
    return {ur, uq};
  endfunction

  // Transaction-level model: accept, completion edge, hold, release.
  bit          m_active, m_ready, m_zero;
  int          cyc, m_done;
  logic [63:0] m_res;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_active = 1'b0;
      m_ready  = 1'b0;
      cyc      = 0;
    end else begin
      cyc++;
      if (m_ready) begin
        if (!start_i || annul_i) begin
          m_ready  = 1'b0;
          m_active = 1'b0;
        end
      end else if (m_active) begin
        if (annul_i && !m_zero) m_active = 1'b0;
        else if (cyc == m_done) m_ready = 1'b1;
      end else if (start_i && !annul_i) begin
        m_active = 1'b1;
        m_zero   = (opdata2_i == 32'd0);
        m_done   = cyc + (m_zero ? 1 : 33);
        m_res    = ref_div(signed_div_i, opdata1_i, opdata2_i);
      end
    end
  end

  always @(negedge clk) begin
    if (checking && rst === 1'b1) begin
      chk("ready", {63'd0, ready_o}, {63'd0, m_ready});
      chk("busy", {63'd0, busy_o}, {63'd0, (m_active || m_ready)});
      chk("result", result_o, m_ready ? m_res : 64'd0);
    end
  end

  task automatic run_div(input bit sd, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input int exp_edges, input string nm);
    int n;
    @(negedge clk);
    annul_i      = 1'b0;
    signed_div_i = sd;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) begin
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = ~sd;
      end
    end while (!ready_o && n < 60);
    chk({nm, "_latency"}, 64'(n), 64'(exp_edges));
    chk({nm, "_result"}, result_o, exp);
    chk({nm, "_model"}, m_res, exp);
    @(posedge clk);
    #1;
    chk({nm, "_hold"}, {63'd0, ready_o}, 64'd1);
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk);
    #1;
    chk({nm, "_drop"}, {63'd0, ready_o}, 64'd0);
  endtask

  initial begin
    rst          = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", {63'd0, ready_o}, 64'd0);
    chk("reset_busy", {63'd0, busy_o}, 64'd0);
    chk("reset_result", result_o, 64'd0);
    @(negedge clk);
    rst      = 1'b1;
    checking = 1'b1;

    run_div(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 34, "u100_7");
    run_div(1'b1, 32'hFFFF_FFF9, 32'h2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 34, "s_m7_2");
    run_div(1'b1, 32'h7, 32'hFFFF_FFFE, {32'h1, 32'hFFFF_FFFD}, 34, "s7_m2");
    run_div(1'b0, 32'd5, 32'd0, 64'd0, 2, "div0");
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 34, "s_min_m1");
    run_div(1'b0, 32'hFFFF_FFFF, 32'd1, {32'h0, 32'hFFFF_FFFF}, 34, "u_max_1");

    // Annul after ten iterations, then an immediate new divide.
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'd50;
    opdata2_i    = 32'd7;
    start_i      = 1'b1;
    repeat (11) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1;
    @(posedge clk);
    #1;
    chk("annul_busy", {63'd0, busy_o}, 64'd0);
    chk("annul_ready", {63'd0, ready_o}, 64'd0);
    run_div(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 34, "u9_3");

    // Asynchronous reset in the middle of a divide.
    @(negedge clk);
    opdata1_i = 32'd1000;
    opdata2_i = 32'd10;
    start_i   = 1'b1;
    repeat (21) @(posedge clk);
    #1;
    chk("mid_busy", {63'd0, busy_o}, 64'd1);
    #1;
    rst = 1'b0;
    #1;
    chk("arst_busy", {63'd0, busy_o}, 64'd0);
    chk("arst_ready", {63'd0, ready_o}, 64'd0);
    chk("arst_result", result_o, 64'd0);
    @(negedge clk);
    start_i = 1'b0;
    rst     = 1'b1;
    run_div(1'b0, 32'd1000, 32'd10, {32'd0, 32'd100}, 34, "u1000_10");
    run_div(1'b1, 32'hFFFF_FF9C, 32'd7, {32'hFFFF_FFFE, 32'hFFFF_FFF2}, 34, "s_m100_7");

    @(negedge clk);
    checking = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
